fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared processor definitions for the fetch stage: datapath width, PC step,
// FSM state encoding and the IF/ID payload layout.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 16;

  localparam logic [XLEN-1:0] PC_STEP       = 16'd2;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 16'hFFFE;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

  // Sequential successor; the 16-bit add wraps FFFE to 0000 naturally.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, ir} buffer between fetch and decode. Registered head, so a
// pushed entry becomes visible the cycle after the push.
module fetch_fifo
  import fetch_stage_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         clear_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         empty, full;
  logic         push_ok, pop_ok;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign pop_ok  = pop_i && !empty;
  // A full buffer may still take a push when the head leaves in the same cycle.
  assign push_ok = push_i && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue to instruction memory,
// in-order response capture into a 2-entry IF/ID buffer, and redirect flushing.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            jump_in,
  input  logic [XLEN-1:0] new_pc_in,
  output logic            out_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] ir_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pcp2_out
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]      out_cnt_q, out_cnt_d;
  logic [1:0]      drop_cnt_q, drop_cnt_d;

  logic [1:0]      fifo_count;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_data;
  logic            credit_ok, accept, rsp_seen, push, pop;
  logic [XLEN-1:0] rsp_pc;

  assign credit_ok = ({1'b0, out_cnt_q} + {1'b0, fifo_count}) < 3'd2;
  assign imem_req  = (state_q == ST_FETCH) && credit_ok && !jump_in;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;
  assign rsp_seen  = imem_rvalid && (out_cnt_q != 2'd0);

  // In FETCH every outstanding request is live and sequential up to
  // fetch_pc_q - 2, so the oldest one sits out_cnt_q steps behind fetch_pc_q.
  assign rsp_pc    = fetch_pc_q - {{(XLEN-3){1'b0}}, out_cnt_q, 1'b0};
  assign push_data = '{pc: rsp_pc, ir: imem_rdata};

  assign push      = (state_q == ST_FETCH) && rsp_seen && !jump_in;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && dec_ready && !jump_in;

  assign out_cnt_d = out_cnt_q + {1'b0, accept} - {1'b0, rsp_seen};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) fetch_pc_d = pc_inc(fetch_pc_q);
    if (jump_in) begin
      // Everything still in flight after this cycle is stale.
      fetch_pc_d = new_pc_in & PC_ALIGN_MASK;
      drop_cnt_d = out_cnt_d;
      state_d    = (out_cnt_d != 2'd0) ? ST_FLUSH : ST_FETCH;
    end else begin
      unique case (state_q)
        ST_BOOT:  state_d = ST_FETCH;
        ST_FETCH: state_d = ST_FETCH;
        ST_FLUSH: begin
          if (rsp_seen) drop_cnt_d = drop_cnt_q - 2'd1;
          if (drop_cnt_d == 2'd0) state_d = ST_FETCH;
        end
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= 2'd0;
      drop_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .clear_i     (jump_in),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  assign ir_out   = fifo_head.ir;
  assign pc_out   = fifo_head.pc;
  assign pcp2_out = pc_inc(fifo_head.pc);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an in-order memory model with a hold switch,
// plus a second instance with RESET_PC = FFFC for the wrap-around case.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        jump_in = 1'b0;
  logic [15:0] new_pc_in = 16'h0000;
  logic        out_valid;
  logic        dec_ready = 1'b1;
  logic [15:0] ir_out, pc_out, pcp2_out;

  logic        req2, rvalid2, valid2;
  logic [15:0] addr2, rdata2, ir2, pc2, p22;

  logic        mem_hold = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [15:0] acc_log[$], out_pc[$], out_ir[$], out_p2[$];
  logic [15:0] acc2_log[$], out2_pc[$], out2_ir[$], out2_p2[$];
  logic [15:0] pend[$];
  logic        acc_n = 1'b0, acc2_n = 1'b0;
  logic [15:0] acc_addr_n = 16'h0000, acc2_addr_n = 16'h0000;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .jump_in(jump_in), .new_pc_in(new_pc_in), .out_valid(out_valid), .dec_ready(dec_ready),
    .ir_out(ir_out), .pc_out(pc_out), .pcp2_out(pcp2_out)
  );

  fetch_stage #(.RESET_PC(16'hFFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(1'b1), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .jump_in(1'b0), .new_pc_in(16'h0000), .out_valid(valid2), .dec_ready(1'b1),
    .ir_out(ir2), .pc_out(pc2), .pcp2_out(p22)
  );

  always #5 clk = ~clk;

  // Sample handshakes mid-cycle; memory data is addr ^ C3C3.
  always @(negedge clk) begin
    acc_n       <= !reset && imem_req && imem_ready;
    acc_addr_n  <= imem_addr;
    acc2_n      <= !reset && req2;
    acc2_addr_n <= addr2;
    if (!reset && imem_req && imem_ready) acc_log.push_back(imem_addr);
    if (!reset && out_valid && dec_ready) begin
      out_pc.push_back(pc_out);
      out_ir.push_back(ir_out);
      out_p2.push_back(pcp2_out);
    end
    if (!reset && req2) acc2_log.push_back(addr2);
    if (!reset && valid2) begin
      out2_pc.push_back(pc2);
      out2_ir.push_back(ir2);
      out2_p2.push_back(p22);
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      imem_rvalid <= 1'b0;
      imem_rdata  <= 16'h0000;
    end else begin
      if (!mem_hold && pend.size() != 0) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= pend[0] ^ 16'hC3C3;
        void'(pend.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
      end
      if (acc_n) pend.push_back(acc_addr_n);
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid2 <= 1'b0;
      rdata2  <= 16'h0000;
    end else begin
      rvalid2 <= acc2_n;
      rdata2  <= acc2_addr_n ^ 16'hC3C3;
    end
  end

  function automatic logic [15:0] at(input logic [15:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 16'hxxxx;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Returns at posedge+1 of cycle 0 (the BOOT cycle).
  task automatic apply_reset();
    reset      = 1'b1;
    jump_in    = 1'b0;
    dec_ready  = 1'b1;
    imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 16'h0000) $display("FAIL rst_addr: got %h want 0000", imem_addr); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (ir_out !== 16'h0000) $display("FAIL rst_ir: got %h want 0000", ir_out); else n_pass++;
    n_checks++; if (pc_out !== 16'h0000) $display("FAIL rst_pc: got %h want 0000", pc_out); else n_pass++;
    n_checks++; if (pcp2_out !== 16'h0002) $display("FAIL rst_pcp2: got %h want 0002", pcp2_out); else n_pass++;
    n_checks++; if (addr2 !== 16'hFFFC) $display("FAIL rst_addr_wrap: got %h want fffc", addr2); else n_pass++;
    apply_reset();
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) $display("FAIL boot_req: got %b want 0", imem_req); else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 16'h0000) $display("FAIL first_addr: got %h want 0000", imem_addr); else n_pass++;
  endtask

  task automatic test_stall();
    apply_reset();
    imem_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
        $display("FAIL stall_hold c%0d: got req %b addr %h want 1 0000", k, imem_req, imem_addr);
      else n_pass++;
    end
    imem_ready = 1'b1;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc [3] = '{16'h0000, 16'h0002, 16'h0004};
    logic [15:0] exp_ir [3] = '{16'hC3C3, 16'hC3C1, 16'hC3C7};
    logic [15:0] exp_p2 [3] = '{16'h0002, 16'h0004, 16'h0006};
    int b_acc, b_out;
    mem_hold = 1'b0;
    apply_reset();
    b_acc = acc_log.size();
    b_out = out_pc.size();
    repeat (14) cyc();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (at(acc_log, b_acc + i) !== exp_pc[i])
        $display("FAIL seq_addr%0d: got %h want %h", i, at(acc_log, b_acc + i), exp_pc[i]);
      else n_pass++;
      n_checks++;
      if (at(out_pc, b_out + i) !== exp_pc[i] || at(out_ir, b_out + i) !== exp_ir[i] ||
          at(out_p2, b_out + i) !== exp_p2[i])
        $display("FAIL seq_out%0d: got pc %h ir %h pcp2 %h want %h %h %h", i,
                 at(out_pc, b_out + i), at(out_ir, b_out + i), at(out_p2, b_out + i),
                 exp_pc[i], exp_ir[i], exp_p2[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int b_acc, b_out;
    apply_reset();
    dec_ready = 1'b0;
    b_acc = acc_log.size();
    b_out = out_pc.size();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (pc_out !== 16'h0000) $display("FAIL bp_pc c%0d: got %h want 0000", k, pc_out);
        else n_pass++;
      end
      cyc();
    end
    n_checks++;
    if (acc_log.size() - b_acc != 2)
      $display("FAIL bp_accepts: got %0d want 2", acc_log.size() - b_acc);
    else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", out_valid); else n_pass++;
    dec_ready = 1'b1;
    repeat (12) cyc();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (at(out_pc, b_out + i) !== 16'(2 * i))
        $display("FAIL bp_order%0d: got %h want %h", i, at(out_pc, b_out + i), 16'(2 * i));
      else n_pass++;
    end
  endtask

  task automatic test_redirect_flush();
    int b_acc, b_out;
    mem_hold = 1'b1;
    apply_reset();
    b_acc = acc_log.size();
    b_out = out_pc.size();
    repeat (4) cyc();
    jump_in   = 1'b1;
    new_pc_in = 16'h0041;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rd_jump_req: got %b want 0", imem_req); else n_pass++;
    for (int k = 5; k <= 8; k++) begin
      cyc();
      jump_in = 1'b0;
      if (k == 6) mem_hold = 1'b0;
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL rd_flush c%0d: got req %b valid %b want 0 0", k, imem_req, out_valid);
      else n_pass++;
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040)
      $display("FAIL rd_resume: got req %b addr %h want 1 0040", imem_req, imem_addr);
    else n_pass++;
    repeat (10) cyc();
    n_checks++;
    if (at(acc_log, b_acc + 2) !== 16'h0040)
      $display("FAIL rd_third_addr: got %h want 0040", at(acc_log, b_acc + 2));
    else n_pass++;
    n_checks++;
    if (at(out_pc, b_out) !== 16'h0040 || at(out_ir, b_out) !== 16'hC383)
      $display("FAIL rd_first_out: got pc %h ir %h want 0040 c383", at(out_pc, b_out), at(out_ir, b_out));
    else n_pass++;
  endtask

  task automatic test_redirect_rvalid();
    int b_out;
    mem_hold = 1'b1;
    apply_reset();
    b_out = out_pc.size();
    repeat (3) cyc();
    mem_hold = 1'b0;
    cyc();
    jump_in   = 1'b1;
    new_pc_in = 16'h1235;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rv_jump_req: got %b want 0", imem_req); else n_pass++;
    cyc();
    jump_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL rv_flush: got req %b valid %b want 0 0", imem_req, out_valid);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h1234 || out_valid !== 1'b0)
      $display("FAIL rv_resume: got req %b addr %h valid %b want 1 1234 0", imem_req, imem_addr, out_valid);
    else n_pass++;
    repeat (10) cyc();
    n_checks++;
    if (at(out_pc, b_out) !== 16'h1234 || at(out_ir, b_out) !== 16'hD1F7 ||
        at(out_p2, b_out) !== 16'h1236)
      $display("FAIL rv_first_out: got pc %h ir %h pcp2 %h want 1234 d1f7 1236",
               at(out_pc, b_out), at(out_ir, b_out), at(out_p2, b_out));
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [3] = '{16'hFFFC, 16'hFFFE, 16'h0000};
    int b_acc, b_out;
    mem_hold = 1'b0;
    apply_reset();
    b_acc = acc2_log.size();
    b_out = out2_pc.size();
    repeat (10) cyc();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (at(acc2_log, b_acc + i) !== exp_a[i])
        $display("FAIL wrap_addr%0d: got %h want %h", i, at(acc2_log, b_acc + i), exp_a[i]);
      else n_pass++;
    end
    n_checks++;
    if (at(out2_pc, b_out) !== 16'hFFFC || at(out2_ir, b_out) !== 16'h3C3F ||
        at(out2_p2, b_out) !== 16'hFFFE)
      $display("FAIL wrap_out0: got pc %h ir %h pcp2 %h want fffc 3c3f fffe",
               at(out2_pc, b_out), at(out2_ir, b_out), at(out2_p2, b_out));
    else n_pass++;
    n_checks++;
    if (at(out2_pc, b_out + 1) !== 16'hFFFE || at(out2_ir, b_out + 1) !== 16'h3C3D ||
        at(out2_p2, b_out + 1) !== 16'h0000)
      $display("FAIL wrap_out1: got pc %h ir %h pcp2 %h want fffe 3c3d 0000",
               at(out2_pc, b_out + 1), at(out2_ir, b_out + 1), at(out2_p2, b_out + 1));
    else n_pass++;
  endtask

  task automatic test_reset_in_flush();
    mem_hold = 1'b1;
    apply_reset();
    repeat (3) cyc();
    jump_in   = 1'b1;
    new_pc_in = 16'h0010;
    cyc();
    jump_in  = 1'b0;
    mem_hold = 1'b0;
    cyc();
    mem_hold = 1'b1;
    cyc();
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0010)
      $display("FAIL rf_pre: got req %b addr %h want 0 0010", imem_req, imem_addr);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || out_valid !== 1'b0)
      $display("FAIL rf_rst_ctl: got req %b addr %h valid %b want 0 0000 0", imem_req, imem_addr, out_valid);
    else n_pass++;
    n_checks++;
    if (ir_out !== 16'h0000 || pc_out !== 16'h0000 || pcp2_out !== 16'h0002)
      $display("FAIL rf_rst_out: got ir %h pc %h pcp2 %h want 0000 0000 0002", ir_out, pc_out, pcp2_out);
    else n_pass++;
    mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rf_boot_req: got %b want 0", imem_req); else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
      $display("FAIL rf_first_req: got req %b addr %h want 1 0000", imem_req, imem_addr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_sequential();
    test_backpressure();
    test_redirect_flush();
    test_redirect_rvalid();
    test_wrap();
    test_reset_in_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
